// File: rtl/scm_port_arbiter_pkg.sv
// Package for the scratch-memory port arbiter: requester ids, the scratch
// map constants and default geometry. The optional burst lock is enabled by
// defining SCM_ARB_LOCK_EN.
package scm_pkg;

  localparam int SCM_NREQ   = 3;
  localparam int SCM_AW     = 16;
  localparam int SCM_DW     = 128;
  localparam int SCM_RD_LAT = 2;

  localparam int REQ_HIST = 0;
  localparam int REQ_DIV  = 1;
  localparam int REQ_MAP  = 2;

  localparam logic [15:0] CDF_BASE = 16'd64;
  localparam logic [15:0] DIV_BASE = 16'd128;

  // Next requester index after idx, wrapping at n-1 back to 0.
  function automatic int rr_next(input int idx, input int n);
    if (idx + 1 >= n) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/scm_port_arbiter_rr.sv
// Round-robin arbiter: searches from the pointer upward with wrap, grants
// at most one requester per cycle, and advances the pointer past the winner
// only when the top accepts the round-robin decision.
module rr_arbiter
  import scm_pkg::*;
#(
  parameter int NREQ = SCM_NREQ
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_accept,
  output logic [NREQ-1:0] o_gnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next;
  logic          w_found;
  int            w_idx;

  // First asserted request at or above the pointer, wrapping past NREQ-1.
  always_comb begin
    o_gnt   = '0;
    w_next  = r_ptr;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end else begin
        w_idx = w_idx;
      end
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        w_next       = PW'(rr_next(w_idx, NREQ));
      end else begin
        w_found = w_found;
      end
    end
  end

  // Pointer moves past the winner on an accepted grant, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_accept && w_found) begin
      r_ptr <= w_next;
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/scm_port_arbiter.sv
// Scratch-memory port arbiter. Grants one master per cycle round-robin,
// registers the SRAM command and returns read data to the owner with a
// fixed 1+RD_LAT cycle latency. Define SCM_ARB_LOCK_EN to add i_req_lock,
// which lets the current owner keep the port for a burst.
module scm_port_arbiter
  import scm_pkg::*;
#(
  parameter int NREQ   = SCM_NREQ,
  parameter int AW     = SCM_AW,
  parameter int DW     = SCM_DW,
  parameter int RD_LAT = SCM_RD_LAT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    i_req,
  input  logic [NREQ-1:0]    i_req_we,
  input  logic [NREQ*AW-1:0] i_req_addr,
  input  logic [NREQ*DW-1:0] i_req_wdata,
`ifdef SCM_ARB_LOCK_EN
  input  logic [NREQ-1:0]    i_req_lock,
`endif
  output logic [NREQ-1:0]    o_gnt,
  output logic [NREQ-1:0]    o_rvalid,
  output logic [DW-1:0]      o_rdata,
  output logic               o_mem_en,
  output logic               o_mem_we,
  output logic [AW-1:0]      o_mem_addr,
  output logic [DW-1:0]      o_mem_wdata,
  input  logic [DW-1:0]      i_mem_rdata,
  output logic               o_busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] w_gnt_rr;
  logic [NREQ-1:0] w_gnt;
  logic            w_accept;
  logic            w_any;
  logic [PW-1:0]   w_win_idx;

  logic            r_mem_en;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;

  logic [RD_LAT-1:0] r_pv;
  logic [PW-1:0]     r_pid [RD_LAT];
  logic [NREQ-1:0]   r_rvalid;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .i_accept (w_accept),
    .o_gnt    (w_gnt_rr)
  );

`ifdef SCM_ARB_LOCK_EN
  logic          r_owner_vld;
  logic [PW-1:0] r_owner;
  logic          w_lock_hit;

  assign w_lock_hit = r_owner_vld & i_req[r_owner] & i_req_lock[r_owner];

  // A locked owner overrides round-robin and freezes the pointer.
  always_comb begin
    w_gnt    = w_gnt_rr;
    w_accept = 1'b1;
    if (w_lock_hit) begin
      w_gnt          = '0;
      w_gnt[r_owner] = 1'b1;
      w_accept       = 1'b0;
    end else begin
      w_gnt    = w_gnt_rr;
      w_accept = 1'b1;
    end
  end

  // Track the requester granted last cycle as the lock candidate.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner_vld <= 1'b0;
      r_owner     <= '0;
    end else begin
      r_owner_vld <= w_any;
      r_owner     <= w_win_idx;
    end
  end
`else
  assign w_gnt    = w_gnt_rr;
  assign w_accept = 1'b1;
`endif

  assign w_any = |w_gnt;

  // Encode the one-hot winner as an index.
  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_win_idx = PW'(i);
      end else begin
        w_win_idx = w_win_idx;
      end
    end
  end

  // Register the winner's command; address and data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_any) begin
      r_mem_en    <= 1'b1;
      r_mem_we    <= i_req_we[w_win_idx];
      r_mem_addr  <= i_req_addr[w_win_idx*AW +: AW];
      r_mem_wdata <= i_req_wdata[w_win_idx*DW +: DW];
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
    end
  end

  // Return pipeline: read grants enter as {valid,id}, the last stage drives rvalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pv     <= '0;
      r_rvalid <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        r_pid[k] <= '0;
      end
    end else begin
      r_pv[0]  <= w_any & ~i_req_we[w_win_idx];
      r_pid[0] <= w_win_idx;
      for (int k = 1; k < RD_LAT; k++) begin
        r_pv[k]  <= r_pv[k-1];
        r_pid[k] <= r_pid[k-1];
      end
      r_rvalid <= '0;
      if (r_pv[RD_LAT-1]) begin
        r_rvalid[r_pid[RD_LAT-1]] <= 1'b1;
      end else begin
        r_rvalid <= '0;
      end
    end
  end

  assign o_gnt       = w_gnt;
  assign o_rvalid    = r_rvalid;
  assign o_rdata     = i_mem_rdata;
  assign o_mem_en    = r_mem_en;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = |r_pv;

endmodule

// File: tb/tb_scm_port_arbiter.sv
// Scoreboard bench for scm_port_arbiter: a transaction-level model predicts
// grants, SRAM commands and read returns; a monitor compares DUT outputs.
`timescale 1ns/1ps
module tb_scm_port_arbiter;
  import scm_pkg::*;

  localparam int NREQ = 3, AW = 16, DW = 128, RD_LAT = 2;
`ifdef SCM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [NREQ-1:0] i_req, i_req_we, i_req_lock;
  logic [NREQ*AW-1:0] i_req_addr;
  logic [NREQ*DW-1:0] i_req_wdata;
  logic [NREQ-1:0] o_gnt, o_rvalid;
  logic [DW-1:0] o_rdata, o_mem_wdata, i_mem_rdata, sram_a;
  logic o_mem_en, o_mem_we, o_busy;
  logic [AW-1:0] o_mem_addr;

  always #5 clk = ~clk;

  scm_port_arbiter dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
`ifdef SCM_ARB_LOCK_EN
    .i_req_lock(i_req_lock),
`endif
    .o_gnt(o_gnt), .o_rvalid(o_rvalid), .o_rdata(o_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
  );

  typedef struct { int cyc; logic [NREQ-1:0] gnt; } gnt_e;
  typedef struct { int due; bit en; bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } cmd_e;
  typedef struct { int due; int id; logic [DW-1:0] data; } rd_e;

  gnt_e gnt_q[$];
  cmd_e cmd_q[$];
  rd_e  rd_q[$];
  bit   rd_hist[int];
  logic [DW-1:0] ref_mem[int];
  logic [DW-1:0] sram_mem[int];

  int cyc = 0;
  int m_ptr, m_own;
  int n_checks = 0, n_pass = 0;
  bit mon_on = 1'b0;

  logic [NREQ-1:0] b_req, b_we, b_lock;
  logic [AW-1:0]   b_addr [NREQ];
  logic [DW-1:0]   b_wdata [NREQ];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] line_init(input int a);
    logic [31:0] v;
    v = a;
    return {2{~v, v}};
  endfunction

  function automatic logic [DW-1:0] ref_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return line_init(a);
  endfunction

  function automatic logic [DW-1:0] sram_rd(input int a);
    if (sram_mem.exists(a)) return sram_mem[a];
    return line_init(a);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int id);
    logic [NREQ-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  // SRAM model: data appears RD_LAT cycles after the cycle mem_en is high.
  always @(posedge clk) begin
    if (o_mem_en && o_mem_we) sram_mem[int'(o_mem_addr)] = o_mem_wdata;
    if (o_mem_en && !o_mem_we) sram_a <= sram_rd(int'(o_mem_addr));
    i_mem_rdata <= sram_a;
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Apply the b_* stimulus for one cycle and push the model's predictions.
  task automatic do_cycle(output int win);
    gnt_e g;
    cmd_e c;
    rd_e  r;
    @(posedge clk); #1;
    i_req = b_req; i_req_we = b_we; i_req_lock = b_lock;
    for (int i = 0; i < NREQ; i++) begin
      i_req_addr[i*AW +: AW]  = b_addr[i];
      i_req_wdata[i*DW +: DW] = b_wdata[i];
    end
    win = -1;
    if (LOCK_EN && m_own >= 0 && b_req[m_own] && b_lock[m_own]) begin
      win = m_own;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (win < 0 && b_req[idx]) win = idx;
      end
      if (win >= 0) m_ptr = (win + 1) % NREQ;
    end
    m_own = win;
    g.cyc = cyc;
    g.gnt = (win >= 0) ? onehot(win) : '0;
    gnt_q.push_back(g);
    c.due = cyc + 1; c.en = (win >= 0); c.we = 1'b0; c.addr = '0; c.wdata = '0;
    if (win >= 0) begin
      c.we = b_we[win]; c.addr = b_addr[win]; c.wdata = b_wdata[win];
      if (b_we[win]) begin
        ref_mem[int'(b_addr[win])] = b_wdata[win];
      end else begin
        r.due = cyc + 1 + RD_LAT; r.id = win; r.data = ref_rd(int'(b_addr[win]));
        rd_q.push_back(r);
        rd_hist[cyc] = 1'b1;
      end
    end
    cmd_q.push_back(c);
  endtask

  task automatic idle(input int n);
    int w;
    b_req = '0; b_lock = '0;
    repeat (n) do_cycle(w);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    b_req = '0; b_lock = '0; i_req = '0; i_req_lock = '0;
    gnt_q.delete(); cmd_q.delete(); rd_q.delete(); rd_hist.delete();
    m_ptr = 0; m_own = -1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mem_en", o_mem_en, 0);
    chk("rst_mem_we", o_mem_we, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    chk("rst_mem_wdata", o_mem_wdata, 0);
    chk("rst_rvalid", o_rvalid, 0);
    chk("rst_busy", o_busy, 0);
  endtask

  gnt_e mg;
  cmd_e mc;
  rd_e  mr;
  bit   exp_busy;

  // Monitor: pop expectations whenever the DUT should present them.
  always @(negedge clk) begin
    if (mon_on && !reset) begin
      if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
        mg = gnt_q.pop_front();
        chk("gnt", o_gnt, mg.gnt);
      end
      if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
        mc = cmd_q.pop_front();
        chk("mem_en", o_mem_en, mc.en);
        chk("mem_we", o_mem_we, mc.we);
        if (mc.en) begin
          chk("mem_addr", o_mem_addr, mc.addr);
          chk("mem_wdata", o_mem_wdata, mc.wdata);
        end
      end
      if (o_rvalid != '0) begin
        if (rd_q.size() == 0) begin
          chk("rvalid_unexpected", o_rvalid, 0);
        end else begin
          mr = rd_q.pop_front();
          chk("rvalid_id", o_rvalid, onehot(mr.id));
          chk("rdata", o_rdata, mr.data);
          chk("rvalid_cycle", cyc, mr.due);
        end
      end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
        mr = rd_q.pop_front();
        chk("rvalid_missing", o_rvalid, onehot(mr.id));
      end
      exp_busy = 1'b0;
      for (int k = 1; k <= RD_LAT; k++) if (rd_hist.exists(cyc - k)) exp_busy = 1'b1;
      chk("busy", o_busy, exp_busy);
    end
  end

  initial begin
    int w;
    bit pend [NREQ];
    reset = 1'b1;
    i_req = '0; i_req_we = '0; i_req_lock = '0; i_req_addr = '0; i_req_wdata = '0;
    i_mem_rdata = '0; sram_a = '0;
    b_req = '0; b_we = '0; b_lock = '0;
    for (int i = 0; i < NREQ; i++) begin b_addr[i] = '0; b_wdata[i] = '0; pend[i] = 1'b0; end
    m_ptr = 0; m_own = -1;
    repeat (2) @(posedge clk);
    mon_on = 1'b1;
    do_reset();

    // Single read by the histogram master at CDF_BASE.
    b_req = 3'b001; b_we = 3'b000; b_addr[REQ_HIST] = CDF_BASE;
    do_cycle(w);
    idle(4);

    // All three reading continuously: 001,010,100,001.
    do_reset();
    b_we = 3'b000; b_req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NREQ; i++) b_addr[i] = CDF_BASE + AW'(4*k + i);
      do_cycle(w);
    end
    idle(4);

    // Write then read-back of the same line by another master.
    b_req = 3'b001; b_we = 3'b001; b_addr[REQ_HIST] = DIV_BASE; b_wdata[REQ_HIST] = {16{8'hA5}};
    do_cycle(w);
    b_req = 3'b010; b_we = 3'b000; b_addr[REQ_DIV] = DIV_BASE;
    do_cycle(w);
    idle(4);

    // Long idle, then a full request checks the pointer held.
    idle(5);
    b_req = 3'b111; b_we = 3'b000;
    do_cycle(w);
    idle(4);

    // Reset one cycle after a read grant: no return, pointer back to 0.
    b_req = 3'b010; b_we = 3'b000; b_addr[REQ_DIV] = CDF_BASE + 16'd3;
    do_cycle(w);
    do_reset();
    idle(4);
    b_req = 3'b111; b_we = 3'b000;
    do_cycle(w);
    idle(4);

`ifdef SCM_ARB_LOCK_EN
    // Divider locks the port against the other two, then releases.
    do_reset();
    b_we = 3'b000; b_req = 3'b010; b_lock = 3'b010;
    do_cycle(w);
    b_req = 3'b111;
    repeat (4) do_cycle(w);
    b_lock = 3'b000;
    do_cycle(w);
    idle(4);
`endif

    // Randomized traffic; each master holds its request until granted.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]    = 1'b1;
          b_we[i]    = 1'($urandom_range(0, 1));
          b_addr[i]  = (($urandom_range(0, 1) == 1) ? CDF_BASE : DIV_BASE) + AW'($urandom_range(0, 7));
          b_wdata[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        b_req[i]  = pend[i];
        b_lock[i] = LOCK_EN && pend[i] && ($urandom_range(0, 1) == 1);
      end
      do_cycle(w);
      if (w >= 0) pend[w] = 1'b0;
    end
    idle(6);
    chk("drain_reads", rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scm_port_arbiter.md
Name: scm_port_arbiter

Overview:
- Shares the single-port scratch memory between the equalizer's three masters: histogram/CDF builder, divider memory controller, and pixel remap unit.
- Grants one access per cycle using a round-robin policy.
- Registers the memory command and returns read data to the owning requester with a fixed-latency valid pulse.
- Sits between the master controllers and the scratch SRAM macro.

Parameters:
- NREQ, 3, number of requesters (id 0..NREQ-1).
- AW, 16, scratch address width.
- DW, 128, scratch data width (one line).
- RD_LAT, 2, SRAM read latency in cycles from registered mem_en to valid mem_rdata.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  NREQ  per-requester access request; held high until granted
- req_we  in  NREQ  1 = write, 0 = read, per requester
- req_addr  in  NREQ*AW  flattened addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  flattened write data
- gnt  out  NREQ  one-hot, combinational; asserted the cycle the request is accepted
- rvalid  out  NREQ  one-hot pulse, read data valid for that requester
- rdata  out  DW  read data, broadcast; qualified by rvalid
- mem_en  out  1  registered SRAM enable
- mem_we  out  1  registered SRAM write enable
- mem_addr  out  AW  registered SRAM address
- mem_wdata  out  DW  registered SRAM write data
- mem_rdata  in  DW  SRAM read data
- busy  out  1  high while any read is in flight in the return pipeline

Behaviour:
- Reset:
  - mem_en, mem_we, rvalid, and busy are 0.
  - mem_addr and mem_wdata are 0.
  - Round-robin pointer is 0.
  - Return pipeline is cleared.
- Arbitration:
  - Each cycle, the winner is the first requester with req=1, searching from the pointer upward with wrap at NREQ-1 -> 0.
  - gnt is the winner one-hot; it is all-zero when no req is asserted.
  - At most one gnt per cycle.
- Pointer update:
  - On a grant to i, the pointer becomes (i+1) mod NREQ at the next edge.
  - With no grant, the pointer holds.
- Command:
  - On the edge after a grant, mem_en=1 and mem_we/addr/wdata take the winner's values.
  - With no grant, mem_en=0 and mem_we=0; addr/wdata hold.
- Read return:
  - Pipeline of depth RD_LAT carrying {valid, id}; a read grant enters with valid=1.
  - rvalid[id] and rdata=mem_rdata are presented RD_LAT cycles after mem_en.
  - Total latency is gnt -> rvalid = 1+RD_LAT cycles (3 at default).
  - Writes produce no rvalid.
- Requester rule:
  - A requester sampling gnt=1 treats the access as accepted that cycle and may change req/addr on the next cycle.
  - Back-to-back grants to the same requester occur only when no other requester is asserting req.
- Simultaneous events: a new read grant and a pipeline retirement in the same cycle are independent; there are no stalls.
- busy: OR of the valid bits in the return pipeline.
- Reset mid-operation:
  - In-flight reads are discarded with no rvalid.
  - A command registered in the same cycle as reset is suppressed (mem_en=0).
- Address width: addresses pass through unmodified; the block performs no range checks.

Optional Feature:
- SCM_ARB_LOCK_EN adds input req_lock[NREQ].
- With the macro defined: while the current owner holds req_lock=1 and req=1, it is granted every cycle and the pointer does not advance. This gives burst access, e.g. the divider write pair. The lock releases when req_lock or req deasserts.
- Without the macro: no port and pure round-robin.

Decomposition:
- Package scm_pkg holds:
  - requester ids REQ_HIST=0, REQ_DIV=1, REQ_MAP=2;
  - scratch map constants CDF_BASE=16'd64 and DIV_BASE=16'd128;
  - default AW, DW, and RD_LAT.
- Sub-module rr_arbiter (NREQ): req and grant_accept in, one-hot gnt out, owns the pointer.

Test Plan:
- Reset, then req=3'b001 with read at addr 64 -> gnt=001 the same cycle; mem_en=1 and mem_addr=64 at +1; rvalid=001 with rdata=line 64 at +3.
- req=3'b111 held with all reads -> grant sequence 001, 010, 100, 001 on consecutive cycles; rvalid follows in the same order 3 cycles later.
- req0 write addr 128 data 0xA5.., req1 read addr 128 in the next cycle -> mem_we=1 then mem_we=0; req1 receives 0xA5.. and no rvalid is issued for the write.
- Read granted, reset asserted 1 cycle later -> rvalid stays 0, busy=0, and the pointer returns to 0.
- With SCM_ARB_LOCK_EN: req1 locked with req0 and req2 requesting -> gnt=010 for 4 cycles; on lock release the next grant is 100.
- Idle (req=0) for 5 cycles -> mem_en=0 throughout and the pointer is unchanged.
